// File: rtl/rr_arbiter_mux.sv
// rr_arbiter_mux: N-to-1 streaming multiplexer with round-robin arbitration.
// A burst (words up to and including in_last) is locked to one channel and
// never interleaved. The output stage is a single registered valid/ready slot;
// in_ready depends combinationally on out_ready so a word can be accepted in
// the same cycle the previous one leaves.
module rr_arbiter_mux #(
   parameter int CHANNELS = 4,
   parameter int BUS_SIZE = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [CHANNELS-1:0]            in_valid,
   input  logic [CHANNELS-1:0]            in_last,
   output logic [CHANNELS-1:0]            in_ready,
   input  logic [CHANNELS*BUS_SIZE-1:0]   data_in,
   output logic [BUS_SIZE-1:0]            data_out,
   output logic                           out_valid,
   output logic                           out_last,
   output logic [$clog2(CHANNELS)-1:0]    out_channel,
   input  logic                           out_ready,
   output logic                           busy
);

   localparam int          CW  = $clog2(CHANNELS);
   localparam int unsigned NCH = CHANNELS;

   typedef logic [CW-1:0] chan_t;
   typedef enum logic {IDLE, LOCKED} state_t;

   // Channel index arithmetic that wraps at CHANNELS (not necessarily a power of two).
   function automatic chan_t wrap_add(chan_t base, int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NCH) begin
         s = s - NCH;
      end
      return chan_t'(s);
   endfunction

   function automatic chan_t next_ch(chan_t ch);
      return (ch == chan_t'(CHANNELS - 1)) ? chan_t'(0) : chan_t'(ch + chan_t'(1));
   endfunction

   state_t              state_reg, state_next;
   chan_t               ptr_reg, ptr_next;
   chan_t               lock_reg, lock_next;
   logic [BUS_SIZE-1:0] data_reg;
   logic                valid_reg;
   logic                last_reg;
   chan_t               chan_reg;

   logic [BUS_SIZE-1:0] chan_data [CHANNELS];
   chan_t               winner;
   logic                any_valid;
   logic                slot_free;
   logic                accept;
   chan_t               accept_ch;

   // Unpack the flat data bus into one word per channel.
   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
         assign chan_data[gi] = data_in[gi*BUS_SIZE +: BUS_SIZE];
      end
   endgenerate

   // Ready is one-hot on the accepted channel, zero otherwise.
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
         assign in_ready[gi] = accept && (accept_ch == chan_t'(gi));
      end
   endgenerate

   assign slot_free   = !valid_reg || out_ready;
   assign data_out    = data_reg;
   assign out_valid   = valid_reg;
   assign out_last    = last_reg;
   assign out_channel = chan_reg;
   assign busy        = (state_reg == LOCKED);

   // Rotating-priority search: first valid channel starting at ptr, wrapping.
   always_comb begin
      winner    = ptr_reg;
      any_valid = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!any_valid && in_valid[wrap_add(ptr_reg, i)]) begin
            winner    = wrap_add(ptr_reg, i);
            any_valid = 1'b1;
         end
      end
   end

   // Arbitration FSM: next state, pointer and lock channel, plus the accept decision.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      lock_next  = lock_reg;
      accept     = 1'b0;
      accept_ch  = winner;
      if (!reset) begin
         case (state_reg)
            IDLE: begin
               if (any_valid && slot_free) begin
                  accept = 1'b1;
                  if (in_last[winner]) begin
                     ptr_next = next_ch(winner);
                  end else begin
                     state_next = LOCKED;
                     lock_next  = winner;
                  end
               end
            end
            LOCKED: begin
               // Only the locked channel may proceed, even if it is momentarily idle.
               accept_ch = lock_reg;
               if (in_valid[lock_reg] && slot_free) begin
                  accept = 1'b1;
                  if (in_last[lock_reg]) begin
                     state_next = IDLE;
                     ptr_next   = next_ch(lock_reg);
                  end
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Arbitration state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         lock_reg  <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         lock_reg  <= lock_next;
      end
   end

   // Output slot: load on accept, empty on a transfer with nothing new behind it.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         last_reg  <= 1'b0;
         chan_reg  <= '0;
      end else if (accept) begin
         valid_reg <= 1'b1;
         data_reg  <= chan_data[accept_ch];
         last_reg  <= in_last[accept_ch];
         chan_reg  <= accept_ch;
      end else if (valid_reg && out_ready) begin
         valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Testbench for rr_arbiter_mux: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_rr_arbiter_mux;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   iv, il, ir;
   logic [127:0] id;
   logic         ordy;
   logic [31:0]  dout;
   logic         ov, ol, busy;
   logic [1:0]   och;

   logic [2:0]   iv3, il3, ir3;
   logic [23:0]  id3;
   logic         ordy3;
   logic [7:0]   dout3;
   logic         ov3, ol3, busy3;
   logic [1:0]   och3;

   int errors = 0;
   int checks = 0;

   // Model state: priority pointer, burst owner, and the output slot contents.
   int          m_ptr;
   bit          m_locked;
   int          m_lock;
   bit          m_ov;
   logic [31:0] m_data;
   bit          m_last;
   int          m_ch;
   logic [3:0]  exp_ready;

   always #5 clk = ~clk;

   rr_arbiter_mux #(.CHANNELS(4), .BUS_SIZE(32)) dut (
      .clk(clk), .reset(rst), .in_valid(iv), .in_last(il), .in_ready(ir),
      .data_in(id), .data_out(dout), .out_valid(ov), .out_last(ol),
      .out_channel(och), .out_ready(ordy), .busy(busy)
   );

   rr_arbiter_mux #(.CHANNELS(3), .BUS_SIZE(8)) dut3 (
      .clk(clk), .reset(rst), .in_valid(iv3), .in_last(il3), .in_ready(ir3),
      .data_in(id3), .data_out(dout3), .out_valid(ov3), .out_last(ol3),
      .out_channel(och3), .out_ready(ordy3), .busy(busy3)
   );

   // Which channel the rules allow to transfer this cycle.
   task automatic model_eval();
      exp_ready = 4'b0000;
      if (!rst && (!m_ov || ordy)) begin
         if (m_locked) begin
            if (iv[m_lock]) exp_ready[m_lock] = 1'b1;
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (iv[(m_ptr + i) % 4]) begin
                  exp_ready[(m_ptr + i) % 4] = 1'b1;
                  break;
               end
            end
         end
      end
   endtask

   task automatic model_commit();
      int acc;
      if (rst) begin
         m_ptr = 0; m_locked = 0; m_lock = 0;
         m_ov = 0; m_data = '0; m_last = 0; m_ch = 0;
      end else begin
         acc = -1;
         for (int k = 0; k < 4; k++) if (exp_ready[k]) acc = k;
         if (acc >= 0) begin
            m_ov = 1; m_data = id[acc*32 +: 32]; m_last = il[acc]; m_ch = acc;
            if (il[acc]) begin
               m_locked = 0;
               m_ptr = (acc + 1) % 4;
            end else begin
               m_locked = 1;
               m_lock = acc;
            end
         end else if (m_ov && ordy) begin
            m_ov = 0;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic advance();
      if (!rst && ov && ordy) $display("xfer ch=%0d data=%h last=%b", och, dout, ol);
      model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; iv = 4'b1111; il = 4'b1111; ordy = 1;
      for (int k = 0; k < 4; k++) id[k*32 +: 32] = 32'hA0 + 32'(k);
      settle();
      checks++;
      if (ir !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", ir); end
      advance();
      advance();
      checks++;
      if ({ov, dout, ol, och, busy} !== 37'd0)
         begin errors++; $display("FAIL reset_outputs: got ov=%b d=%h l=%b ch=%0d busy=%b want all zero", ov, dout, ol, och, busy); end
   endtask

   task automatic test_round_robin();
      logic [3:0] want;
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         settle();
         want = 4'b0001 << (i % 4);
         checks++;
         if (ir !== want) begin errors++; $display("FAIL rr_ready %0d: got %b want %b", i, ir, want); end
         advance();
         checks++;
         if (dout !== 32'hA0 + 32'(i % 4) || och !== 2'(i % 4) || ov !== 1'b1)
            begin errors++; $display("FAIL rr_out %0d: got d=%h ch=%0d ov=%b want d=%h ch=%0d ov=1", i, dout, och, ov, 32'hA0 + 32'(i % 4), i % 4); end
      end
   endtask

   task automatic test_burst_lock();
      logic [31:0] words [3];
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
      iv = 4'b0101; il = 4'b0001; id[0 +: 32] = 32'hC0;
      for (int j = 0; j < 3; j++) begin
         id[64 +: 32] = words[j];
         il[2] = (j == 2);
         settle();
         checks++;
         if (ir !== 4'b0100 || busy !== (j != 0))
            begin errors++; $display("FAIL burst_ready %0d: got ready=%b busy=%b want 0100 busy=%b", j, ir, busy, j != 0); end
         advance();
         checks++;
         if (dout !== words[j] || och !== 2'd2 || busy !== (j != 2))
            begin errors++; $display("FAIL burst_out %0d: got d=%h ch=%0d busy=%b want d=%h ch=2 busy=%b", j, dout, och, busy, words[j], j != 2); end
      end
      iv = 4'b0001;
      settle();
      checks++;
      if (ir !== 4'b0001) begin errors++; $display("FAIL burst_after_ready: got %b want 0001", ir); end
      advance();
      checks++;
      if (dout !== 32'hC0 || och !== 2'd0) begin errors++; $display("FAIL burst_after_out: got d=%h ch=%0d want d=000000c0 ch=0", dout, och); end
   endtask

   task automatic test_lock_stall();
      iv = 4'b0010; il = 4'b0000; id[32 +: 32] = 32'h100;
      settle();
      advance();
      iv = 4'b1000; il = 4'b1000; id[96 +: 32] = 32'h300;
      for (int s = 0; s < 3; s++) begin
         settle();
         checks++;
         if (ir !== 4'b0000) begin errors++; $display("FAIL stall_ready %0d: got %b want 0000", s, ir); end
         advance();
         checks++;
         if (ov !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall_out %0d: got ov=%b busy=%b want ov=0 busy=1", s, ov, busy); end
      end
      iv = 4'b1010; il = 4'b1010; id[32 +: 32] = 32'h101;
      settle();
      checks++;
      if (ir !== 4'b0010) begin errors++; $display("FAIL resume_ready: got %b want 0010", ir); end
      advance();
      checks++;
      if (dout !== 32'h101 || och !== 2'd1 || busy !== 1'b0)
         begin errors++; $display("FAIL resume_out: got d=%h ch=%0d busy=%b want d=00000101 ch=1 busy=0", dout, och, busy); end
      iv = 4'b1000;
      settle();
      advance();
      checks++;
      if (dout !== 32'h300 || och !== 2'd3) begin errors++; $display("FAIL resume_next: got d=%h ch=%0d want d=00000300 ch=3", dout, och); end
      iv = 4'b0000;
      settle();
      advance();
   endtask

   task automatic test_backpressure();
      iv = 4'b0001; il = 4'b0001; id[0 +: 32] = 32'hDEADBEEF;
      settle();
      advance();
      id[0 +: 32] = 32'h12345678;
      ordy = 0;
      for (int s = 0; s < 5; s++) begin
         settle();
         checks++;
         if (ir !== 4'b0000) begin errors++; $display("FAIL bp_ready %0d: got %b want 0000", s, ir); end
         advance();
         checks++;
         if (dout !== 32'hDEADBEEF || ov !== 1'b1) begin errors++; $display("FAIL bp_hold %0d: got d=%h ov=%b want d=deadbeef ov=1", s, dout, ov); end
      end
      ordy = 1;
      settle();
      checks++;
      if (ir !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b want 0001", ir); end
      advance();
      checks++;
      if (dout !== 32'h12345678 || ov !== 1'b1) begin errors++; $display("FAIL bp_release_out: got d=%h ov=%b want d=12345678 ov=1", dout, ov); end
      iv = 4'b0000;
      settle();
      advance();
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL bp_drain: got ov=%b want 0", ov); end
   endtask

   task automatic test_reset_mid_burst();
      iv = 4'b0100; il = 4'b0000; id[64 +: 32] = 32'h55;
      settle();
      advance();
      rst = 1; iv = 4'b1111; il = 4'b1111;
      for (int k = 0; k < 4; k++) id[k*32 +: 32] = 32'hA0 + 32'(k);
      settle();
      checks++;
      if (ir !== 4'b0000) begin errors++; $display("FAIL midrst_ready: got %b want 0000", ir); end
      advance();
      checks++;
      if (ov !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_out: got ov=%b busy=%b want ov=0 busy=0", ov, busy); end
      rst = 0;
      settle();
      checks++;
      if (ir !== 4'b0001) begin errors++; $display("FAIL midrst_restart: got %b want 0001", ir); end
      advance();
      checks++;
      if (och !== 2'd0 || dout !== 32'hA0) begin errors++; $display("FAIL midrst_first: got ch=%0d d=%h want ch=0 d=000000a0", och, dout); end
      iv = 4'b0000;
      settle();
      advance();
   endtask

   task automatic test_random();
      logic [3:0] taken;
      taken = 4'b0000;
      for (int c = 0; c < 300; c++) begin
         rst = (c == 150);
         for (int k = 0; k < 4; k++) begin
            if (taken[k]) iv[k] = 1'b0;
            if (!iv[k] && ($urandom % 3 == 0)) begin
               iv[k] = 1'b1;
               il[k] = ($urandom % 3 == 0);
               id[k*32 +: 32] = $urandom;
            end
         end
         ordy = ($urandom % 4 != 0);
         settle();
         checks++;
         if (ir !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, ir, exp_ready); end
         checks++;
         if ({ov, dout, ol, och, busy} !== {m_ov, m_data, m_last, 2'(m_ch), m_locked})
            begin errors++; $display("FAIL rand_out cyc %0d: got ov=%b d=%h l=%b ch=%0d busy=%b want ov=%b d=%h l=%b ch=%0d busy=%b",
               c, ov, dout, ol, och, busy, m_ov, m_data, m_last, m_ch, m_locked); end
         taken = exp_ready;
         advance();
      end
      rst = 0; iv = 4'b0000; ordy = 1;
      settle();
      advance();
   endtask

   task automatic test_three_channels();
      iv3 = 3'b111; il3 = 3'b111; id3 = 24'h323130; ordy3 = 1;
      for (int i = 0; i < 4; i++) begin
         settle();
         checks++;
         if (ir3 !== (3'b001 << (i % 3))) begin errors++; $display("FAIL ch3_ready %0d: got %b want %b", i, ir3, 3'b001 << (i % 3)); end
         advance();
         $display("xfer3 ch=%0d data=%h", och3, dout3);
         checks++;
         if (och3 !== 2'(i % 3) || dout3 !== 8'h30 + 8'(i % 3) || ov3 !== 1'b1)
            begin errors++; $display("FAIL ch3_out %0d: got ch=%0d d=%h ov=%b want ch=%0d d=%h ov=1", i, och3, dout3, ov3, i % 3, 8'h30 + 8'(i % 3)); end
      end
      iv3 = 3'b000;
   endtask

   initial begin
      rst = 1; iv = '0; il = '0; id = '0; ordy = 1;
      iv3 = '0; il3 = '0; id3 = '0; ordy3 = 1;
      m_ptr = 0; m_locked = 0; m_lock = 0; m_ov = 0; m_data = '0; m_last = 0; m_ch = 0;
      exp_ready = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_round_robin();
      test_burst_lock();
      test_lock_stall();
      test_backpressure();
      test_reset_mid_burst();
      test_random();
      test_three_channels();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_mux.md
# rr_arbiter_mux

Parametrised N-to-1 streaming multiplexer with round-robin arbitration, burst locking and a registered valid/ready output stage. It succeeds the combinational selector mux wherever several producers share one consumer, e.g. debug-unit/UART transmit paths and multi-source write-back. Channel choice is made internally, not by a `selector` input. A burst (words up to and including `in_last`) is never interleaved with another channel.

## Interface
- `CHANNELS`, 4, number of input channels; legal range 2..32, power of two not required.
- `BUS_SIZE`, 32, width of one data word.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  CHANNELS  bit k: channel k offers a word.
- `in_last`  in  CHANNELS  bit k: offered word ends channel k's burst.
- `in_ready`  out  CHANNELS  bit k: channel k's word is accepted this cycle. One-hot or zero.
- `data_in`  in  CHANNELS*BUS_SIZE  channel k at bits [k*BUS_SIZE +: BUS_SIZE].
- `data_out`  out  BUS_SIZE  registered output word.
- `out_valid`  out  1  `data_out` holds a word.
- `out_last`  out  1  registered `in_last` of the output word.
- `out_channel`  out  $clog2(CHANNELS)  source channel of the output word.
- `out_ready`  in  1  consumer accepts the output word.
- `busy`  out  1  a burst is locked (state LOCKED).

## Operation
- Accept rule: channel k transfers when `in_valid[k] && in_ready[k]`. Output transfers when `out_valid && out_ready`.
- Sources hold valid, data and last stable until accepted.
- slot_free = `!out_valid || out_ready`. `in_ready` is combinational from state, `in_valid` and `out_ready`. It is all-zero while `reset`=1.
- Rotating pointer `ptr` (0..CHANNELS-1) marks the highest-priority channel. Winner is the first k with `in_valid[k]=1`, searching `ptr`, `ptr+1`, …, wrapping CHANNELS-1 to 0.
- **State IDLE:**
  - If any `in_valid` is set and slot_free: `in_ready[winner]`=1 and the word loads into the output register.
  - If the accepted word has `in_last`=0: go to LOCKED, lock_ch = winner.
  - If `in_last`=1: stay in IDLE, `ptr` = winner+1 (mod CHANNELS).
  - If not slot_free: nothing is accepted and the winner is re-evaluated next cycle. There is no grant until a word is accepted.
- **State LOCKED:**
  - Only lock_ch may be ready: `in_ready[lock_ch]` = `in_valid[lock_ch] && slot_free`. Other channels get 0 even if lock_ch is idle.
  - When a word with `in_last`=1 is accepted: go to IDLE, `ptr` = lock_ch+1 (mod CHANNELS).
- Output register load: `data_out`, `out_last` and `out_channel` take the accepted word, and `out_valid`=1.
- If an output transfer happens with no new load, `out_valid`=0. `data_out`, `out_last` and `out_channel` hold their last values.
- Simultaneous output transfer and load in the same cycle: the new word replaces the old one and `out_valid` stays 1.
- `busy` = (state == LOCKED).

## Timing
- Reset values (cycle after `reset` sampled high):
  - `out_valid`=0, `data_out`=0, `out_last`=0, `out_channel`=0, `busy`=0.
  - State IDLE, `ptr`=0, lock_ch=0.
- Reset mid-burst drops the lock and discards any pending output word.
- Latency: a word accepted at edge N appears on `data_out` with `out_valid`=1 after edge N.
- Throughput: one word per cycle while `out_ready` stays 1.
- Back-to-back single-word bursts from different channels need no idle cycle.
- When `out_ready`=0 and `out_valid`=1, `in_ready` is all-zero. No word is dropped or duplicated.
- Combinational path `out_ready` → `in_ready` is intentional; there is no skid buffer.

## Test plan
- Reset with `in_valid`=4'b1111, `out_ready`=1 → `in_ready`=0 during reset. Then single-word bursts (all `in_last`=1, data 0xA0+k) emerge as 0xA0, 0xA1, 0xA2, 0xA3, 0xA0 on consecutive cycles, with `out_channel` 0,1,2,3,0.
- Channel 2 sends a 3-word burst 0x11,0x22,0x33 (last on third) while channel 0 is constantly valid → output 0x11,0x22,0x33 all from channel 2, `busy`=1 until the 0x33 accept. The next output is from channel 3 if valid, otherwise from channel 0.
- In LOCKED on channel 1, `in_valid[1]` drops for 3 cycles while channel 3 is valid → `in_ready[3]` stays 0, no output loads, and the burst resumes when channel 1 is valid again.
- `out_ready`=0 for 5 cycles with channel 0 valid (data 0xDEADBEEF) → `data_out`=0xDEADBEEF held and `in_ready`=0. When `out_ready` returns to 1 the word transfers exactly once, and the next word loads in the same cycle.
- `reset` pulsed mid-burst with `out_valid`=1 → next cycle `out_valid`=0, `busy`=0, `ptr`=0, and arbitration restarts from channel 0.
- Run with CHANNELS=3, BUS_SIZE=8 and all valid → grant order 0,1,2,0 (wrap at 2), with `out_channel` 2 bits wide.
